// File: rtl/sorteio_ctrl.sv
// Prize-draw controller: shifts in a 4-bit code, awards saturating prizes, holds the result until ack or timeout.
// All outputs registered; one state transition per clk, strobes outside their accepting states are dropped.
module sorteio_ctrl #(
  parameter logic [3:0] CODE_P1    = 4'b1011,
  parameter logic [3:0] CODE_P2    = 4'b0110,
  parameter int         MAX_PREMIO = 9,
  parameter int         TIMEOUT    = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       ack,
  output logic [1:0] premio_f,
  output logic [4:0] p1_f,
  output logic [4:0] p2_f,
  output logic [3:0] state_f
);

  typedef enum logic [3:0] {
    S0  = 4'b0000,
    S1  = 4'b0001,
    S2  = 4'b0010,
    S3  = 4'b0011,
    S4  = 4'b0100,
    SG1 = 4'b0101,
    SG2 = 4'b0110,
    SG0 = 4'b0111,
    SGX = 4'b1000
  } state_t;

  localparam logic [4:0]  MAXP = 5'(MAX_PREMIO);
  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  code;
  logic [31:0] tcnt;

  assign state_f = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S0;
      code     <= 4'b0000;
      tcnt     <= 32'd0;
      premio_f <= 2'b00;
      p1_f     <= 5'd0;
      p2_f     <= 5'd0;
    end else begin
      case (state)
        S0, S1, S2, S3: begin
          if (bit_valid) begin
            code <= {code[2:0], bit_in};
            case (state)
              S0:      state <= S1;
              S1:      state <= S2;
              S2:      state <= S3;
              default: state <= S4;
            endcase
          end
        end
        // Prize 1 wins ties; a saturated counter falls through to the next option.
        S4: begin
          if (code == CODE_P1 && p1_f < MAXP) begin
            state    <= SG1;
            p1_f     <= p1_f + 5'd1;
            premio_f <= 2'b01;
          end else if (code == CODE_P2 && p2_f < MAXP) begin
            state    <= SG2;
            p2_f     <= p2_f + 5'd1;
            premio_f <= 2'b10;
          end else begin
            state    <= SG0;
            premio_f <= 2'b00;
          end
        end
        SG1, SG2, SG0: begin
          state <= SGX;
          tcnt  <= 32'd0;
        end
        SGX: begin
          if (ack || tcnt == TLIM) begin
            state    <= S0;
            premio_f <= 2'b00;
            code     <= 4'b0000;
            tcnt     <= 32'd0;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        default: state <= S0;
      endcase
    end
  end

endmodule

// File: doc/sorteio_ctrl.md
SORTEIO_CTRL -- requirements
Module: sorteio_ctrl

Interface
REQ-001 SHALL have parameter CODE_P1, default 4'b1011: the 4-bit code that wins prize 1.
REQ-002 SHALL have parameter CODE_P2, default 4'b0110: the 4-bit code that wins prize 2.
REQ-003 SHALL have parameter MAX_PREMIO, default 9: the saturation limit of each prize counter.
REQ-004 SHALL have parameter TIMEOUT, default 50_000_000: cycles spent in sgx before automatic return to s0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port bit_in, input, 1 bit: the code bit, sampled only when bit_valid=1.
REQ-008 SHALL have port bit_valid, input, 1 bit: a single-cycle strobe, synchronous to clk.
REQ-009 SHALL have port ack, input, 1 bit: a single-cycle strobe that releases the result state.
REQ-010 SHALL have port premio_f, output, 2 bits: 00 none, 01 prize 1, 10 prize 2; 11 never driven.
REQ-011 SHALL have port p1_f, output, 5 bits: prize-1 award count, range 0..MAX_PREMIO.
REQ-012 SHALL have port p2_f, output, 5 bits: prize-2 award count, range 0..MAX_PREMIO.
REQ-013 SHALL have port state_f, output, 4 bits: the current FSM state encoding.

Function
REQ-014 State encodings SHALL be: s0=0000, s1=0001, s2=0010, s3=0011, s4=0100, sg1=0101, sg2=0110, sg0=0111, sgx=1000.
REQ-015 Every output SHALL be registered, and state_f SHALL equal the current state register.
REQ-016 In s0, s1, s2 and s3, bit_valid=1 SHALL shift bit_in into a 4-bit code register (MSB first) and advance s0->s1->s2->s3->s4.
REQ-017 Without bit_valid, s0..s3 SHALL hold state indefinitely.
REQ-018 s4 SHALL last exactly one cycle and SHALL evaluate the complete 4-bit code.
REQ-019 From s4 the next state SHALL be, in priority order: sg1 if code==CODE_P1 and p1_f<MAX_PREMIO; else sg2 if code==CODE_P2 and p2_f<MAX_PREMIO; else sg0.
REQ-020 On the s4->sg1 edge, p1_f SHALL increment by 1 and premio_f SHALL become 01.
REQ-021 On the s4->sg2 edge, p2_f SHALL increment by 1 and premio_f SHALL become 10.
REQ-022 On the s4->sg0 edge, premio_f SHALL become 00 and neither counter SHALL change.
REQ-023 Counters SHALL saturate: a matching code with its counter at MAX_PREMIO SHALL route to sg0 with no wrap to 0.
REQ-024 sg1, sg2 and sg0 SHALL each last exactly one cycle, then go to sgx.
REQ-025 In sgx, premio_f SHALL hold its value and a timeout counter SHALL count cycles starting from 0.
REQ-026 sgx SHALL exit to s0 on ack=1, or on the cycle the timeout counter reaches TIMEOUT-1, whichever comes first.
REQ-027 On the sgx->s0 edge, premio_f SHALL become 00 and the code register and timeout counter SHALL clear.
REQ-028 bit_valid SHALL be ignored in s4, sg1, sg2, sg0 and sgx; bits arriving there SHALL be discarded, not buffered.
REQ-029 ack SHALL be ignored in every state other than sgx.
REQ-030 If ack and bit_valid are both 1 in sgx, sgx SHALL go to s0 and the bit SHALL be discarded.
REQ-031 p1_f and p2_f SHALL persist across game rounds and SHALL clear only on reset.

Reset
REQ-032 reset=0 SHALL immediately, without waiting for clk, force state_f=s0, premio_f=00, p1_f=0, p2_f=0, code register=0 and timeout counter=0.
REQ-033 A reset asserted mid-code (s1..s3) or in sgx SHALL abandon the round with no counter update.
REQ-034 After reset deasserts, the first rising clk edge SHALL evaluate s0 normally.

Verification
REQ-035 Bits 1,0,1,1 with defaults -> state_f 1,2,3,4, then 5 one cycle later; premio_f=01 and p1_f=1 from entry to sg1; state_f=8 next cycle.
REQ-036 Bits 0,1,1,0, then ack 3 cycles into sgx -> p2_f=1 and premio_f=10 through sgx; s0 with premio_f=00 on the edge after ack.
REQ-037 Bits 0,0,0,0 -> sg0; premio_f=00 and both counters unchanged; with TIMEOUT=8 and no ack, s0 exactly 8 cycles after entering sgx.
REQ-038 Ten CODE_P1 rounds with MAX_PREMIO=9 -> p1_f counts 1..9, the tenth round goes to sg0 and p1_f stays 9.
REQ-039 bit_valid pulses in s4, sg1 and sgx are discarded, and ack in s2 is ignored -> the code in progress is unaffected.
REQ-040 reset=0 asynchronously mid-clock while in s3 with p2_f=3 -> all outputs zero before the next edge; a new round then proceeds normally.
